// File: rtl/fpga_temperature_monitor_pkg.sv
// rtl/fpga_temperature_monitor_pkg.sv - shared types and timing helpers for the temperature monitor
package temp_mon_pkg;

   localparam int TEMP_W = 8;

   typedef enum logic [1:0] {WAIT, START, CONV, REPORT} state_e;

   function automatic longint calc_ticks(input longint interval_ms, input longint freq_hz);
      return interval_ms * (freq_hz / 1000);
   endfunction

   // Rounded up so a conversion is never sampled before the macro finishes.
   function automatic longint calc_conv_ticks(input longint conv_ns, input longint freq_hz);
      return (conv_ns * freq_hz + 999_999_999) / 1_000_000_000;
   endfunction

endpackage

// File: rtl/fpga_temperature_monitor_if.sv
// rtl/fpga_temperature_monitor_if.sv - control/status and DTR macro signals of the temperature monitor
interface fpga_temperature_monitor_if;
   import temp_mon_pkg::*;

   logic              i_Enable;
   logic              i_Trigger;
   logic              i_ClearMinMax;
   logic [TEMP_W-1:0] i_HighThresh;
   logic [TEMP_W-1:0] o_Temperature;
   logic              o_Valid;
   logic [TEMP_W-1:0] o_TempMin;
   logic [TEMP_W-1:0] o_TempMax;
   logic              o_Alarm;
   logic              o_Busy;
   logic              o_DtrStart;
   logic [TEMP_W-1:0] i_DtrCode;

   modport slave (
      input  i_Enable, i_Trigger, i_ClearMinMax, i_HighThresh, i_DtrCode,
      output o_Temperature, o_Valid, o_TempMin, o_TempMax, o_Alarm, o_Busy, o_DtrStart
   );

   modport master (
      output i_Enable, i_Trigger, i_ClearMinMax, i_HighThresh, i_DtrCode,
      input  o_Temperature, o_Valid, o_TempMin, o_TempMax, o_Alarm, o_Busy, o_DtrStart
   );

endinterface

// File: rtl/fpga_temperature_monitor_dtr_sampler.sv
// rtl/fpga_temperature_monitor_dtr_sampler.sv - DTR macro start pulse and conversion timing
module dtr_sampler
   import temp_mon_pkg::*;
#(
   parameter int CONV_TICKS = 5
) (
   input  logic              i_Clk,
   input  logic              i_Rst,
   input  logic              i_Req,
   input  logic              i_Abort,
   input  logic [TEMP_W-1:0] i_DtrCode,
   output logic              o_DtrStart,
   output logic              o_Done,
   output logic [TEMP_W-1:0] o_Code
);
   localparam int CNT_W = (CONV_TICKS > 1) ? $clog2(CONV_TICKS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONV_TICKS - 1);

   logic             busy_q, busy_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             last_cycle;

   // Start is combinational so an asynchronous reset of the requester kills it at once.
   assign o_DtrStart = i_Req && !i_Abort;
   assign last_cycle = busy_q && (cnt_q == CNT_LAST);
   assign o_Done     = last_cycle && !i_Abort;
   assign o_Code     = i_DtrCode;

   always_comb begin
      busy_d = busy_q;
      cnt_d  = cnt_q;
      if (i_Abort) begin
         busy_d = 1'b0;
         cnt_d  = '0;
      end else if (o_DtrStart) begin
         busy_d = 1'b1;
         cnt_d  = '0;
      end else if (last_cycle) begin
         busy_d = 1'b0;
         cnt_d  = '0;
      end else if (busy_q) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/fpga_temperature_monitor.sv
// rtl/fpga_temperature_monitor.sv - periodic averaged DTR temperature reporting with min/max and alarm
module fpga_temperature_monitor
   import temp_mon_pkg::*;
#(
   parameter int SYSTEM_FREQUENCY    = 15000000,
   parameter int MEASURE_INTERVAL_MS = 5000,
   parameter int CONV_TIME_NS        = 71000,
   parameter int AVG_LOG2            = 2,
   parameter int HYST                = 2
) (
   input logic i_Clk,
   input logic i_Rst,
   fpga_temperature_monitor_if.slave bus
);
   localparam longint TICKS      = calc_ticks(MEASURE_INTERVAL_MS, SYSTEM_FREQUENCY);
   localparam longint CONV_TICKS = calc_conv_ticks(CONV_TIME_NS, SYSTEM_FREQUENCY);
   localparam int IVL_W = (TICKS > 1) ? $clog2(TICKS) : 1;
   localparam int SMP_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam int ACC_W = TEMP_W + AVG_LOG2;
   localparam logic [IVL_W-1:0] IVL_LAST = IVL_W'(TICKS - 1);
   localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'((1 << AVG_LOG2) - 1);

   state_e            state_q, state_d;
   logic [IVL_W-1:0]  ivl_q, ivl_d;
   logic [SMP_W-1:0]  smp_q, smp_d;
   logic [ACC_W-1:0]  acc_q, acc_d, acc_sum;
   logic [TEMP_W-1:0] temp_q, temp_d, min_q, min_d, max_q, max_d, thresh_lo, conv_code;
   logic              first_q, first_d, alarm_q, alarm_d;
   logic              req, conv_done, abort;

   assign abort = !bus.i_Enable;

   dtr_sampler #(.CONV_TICKS(int'(CONV_TICKS))) u_sampler (
      .i_Clk      (i_Clk),
      .i_Rst      (i_Rst),
      .i_Req      (req),
      .i_Abort    (abort),
      .i_DtrCode  (bus.i_DtrCode),
      .o_DtrStart (bus.o_DtrStart),
      .o_Done     (conv_done),
      .o_Code     (conv_code)
   );

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) state_q <= WAIT;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = WAIT;
      end else begin
         case (state_q)
            WAIT:    if (bus.i_Trigger || ivl_q == IVL_LAST) state_d = START;
            START:   state_d = CONV;
            CONV:    if (conv_done) state_d = (smp_q == SMP_LAST) ? REPORT : START;
            REPORT:  state_d = WAIT;
            default: state_d = WAIT;
         endcase
      end
   end

   always_comb begin
      req         = (state_q == START);
      bus.o_Valid = (state_q == REPORT) && bus.i_Enable;
      bus.o_Busy  = (state_q != WAIT);
   end

   // The average is latched on entry to REPORT so it is already visible while o_Valid is high.
   always_comb begin
      ivl_d     = ivl_q;
      smp_d     = smp_q;
      acc_d     = acc_q;
      temp_d    = temp_q;
      min_d     = min_q;
      max_d     = max_q;
      first_d   = first_q;
      alarm_d   = alarm_q;
      acc_sum   = acc_q + ACC_W'(conv_code);
      thresh_lo = (bus.i_HighThresh > TEMP_W'(HYST)) ? bus.i_HighThresh - TEMP_W'(HYST) : '0;
      if (bus.i_ClearMinMax) begin
         min_d   = '1;
         max_d   = '0;
         first_d = 1'b0;
      end
      if (abort) begin
         ivl_d = '0;
         smp_d = '0;
         acc_d = '0;
      end else begin
         case (state_q)
            WAIT: ivl_d = (state_d == START) ? '0 : ivl_q + 1'b1;
            CONV: if (conv_done) begin
               acc_d = acc_sum;
               smp_d = smp_q + 1'b1;
               if (smp_q == SMP_LAST) temp_d = TEMP_W'(acc_sum >> AVG_LOG2);
            end
            REPORT: begin
               ivl_d = '0;
               smp_d = '0;
               acc_d = '0;
               if (bus.i_ClearMinMax || !first_q) begin
                  min_d   = temp_q;
                  max_d   = temp_q;
                  first_d = 1'b1;
               end else begin
                  if (temp_q < min_q) min_d = temp_q;
                  if (temp_q > max_q) max_d = temp_q;
               end
               if (temp_q >= bus.i_HighThresh) alarm_d = 1'b1;
               else if (temp_q < thresh_lo)    alarm_d = 1'b0;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         ivl_q   <= '0;
         smp_q   <= '0;
         acc_q   <= '0;
         temp_q  <= '0;
         min_q   <= '1;
         max_q   <= '0;
         first_q <= 1'b0;
         alarm_q <= 1'b0;
      end else begin
         ivl_q   <= ivl_d;
         smp_q   <= smp_d;
         acc_q   <= acc_d;
         temp_q  <= temp_d;
         min_q   <= min_d;
         max_q   <= max_d;
         first_q <= first_d;
         alarm_q <= alarm_d;
      end
   end

   assign bus.o_Temperature = temp_q;
   assign bus.o_TempMin     = min_q;
   assign bus.o_TempMax     = max_q;
   assign bus.o_Alarm       = alarm_q;

endmodule
